// File: rtl/mesi_isc_pkg.sv
// Shared mbus definitions: command codes used by mesi_isc, the CPU models and the
// memory responder, plus the memory responder FSM state type.
package mesi_isc_pkg;

    localparam logic [2:0] MBUS_CMD_NOP      = 3'd0;
    localparam logic [2:0] MBUS_CMD_WR       = 3'd1;
    localparam logic [2:0] MBUS_CMD_RD       = 3'd2;
    localparam logic [2:0] MBUS_CMD_WR_BROAD = 3'd3;
    localparam logic [2:0] MBUS_CMD_RD_BROAD = 3'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } mesi_isc_mem_state_t;

    // Only plain RD/WR reach memory; broadcasts and codes 5-7 are not ours.
    function automatic logic is_mem_cmd(input logic [2:0] cmd);
        return (cmd == MBUS_CMD_WR) || (cmd == MBUS_CMD_RD);
    endfunction

endpackage

// File: rtl/mesi_isc_mbus_mem_if.sv
// Bundle of the four packed CPU mbus ports as seen by the memory responder.
// master = CPU/bus side, slave = mesi_isc_mbus_mem.
interface mesi_isc_mbus_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import mesi_isc_pkg::*;

    // Handshake: a CPU raises a RD/WR cmd and holds cmd/addr/data until its
    // mbus_ack_o bit is seen high for one cycle; it must drop the cmd in that
    // same ack cycle or the held cmd is taken as a new request.
    logic [4*3-1:0]          mbus_cmd_i;
    logic [4*ADDR_WIDTH-1:0] mbus_addr_i;
    logic [4*DATA_WIDTH-1:0] mbus_data_wr_i;
    logic [3:0]              isc_mbus_ack_i;
    logic [3:0]              mbus_ack_o;
    logic [DATA_WIDTH-1:0]   mbus_data_rd_o;
    logic                    busy_o;
    mesi_isc_mem_state_t     state;

    modport master (
        output mbus_cmd_i, mbus_addr_i, mbus_data_wr_i, isc_mbus_ack_i,
        input  mbus_ack_o, mbus_data_rd_o, busy_o, state
    );

    modport slave (
        input  mbus_cmd_i, mbus_addr_i, mbus_data_wr_i, isc_mbus_ack_i,
        output mbus_ack_o, mbus_data_rd_o, busy_o, state
    );

endinterface

// File: rtl/mesi_isc_mem_arb.sv
// 4-way round-robin arbiter; searches from ptr upward and moves ptr past the
// winner whenever advance is pulsed.
module mesi_isc_mem_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       advance,
    output logic [3:0] grant,
    output logic [1:0] grant_idx
);

    logic [1:0] ptr;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        grant_idx = 2'd0;
        found     = 1'b0;
        idx       = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        grant = found ? (4'b0001 << grant_idx) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 2'd0;
        end else if (advance) begin
            ptr <= grant_idx + 2'd1;
        end
    end

endmodule

// File: rtl/mesi_isc_mbus_mem.sv
// Fixed-latency main-memory responder for plain mbus RD/WR from four CPUs.
// Define MESI_ISC_MEM_STATS_EN to add saturating read/write ack counters.
module mesi_isc_mbus_mem
    import mesi_isc_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int LATENCY    = 2
) (
    input  logic clk,
    input  logic rst,
    mesi_isc_mbus_mem_if.slave bus
`ifdef MESI_ISC_MEM_STATS_EN
    ,
    output logic [15:0] rd_count_o,
    output logic [15:0] wr_count_o
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mesi_isc_mem_state_t   state;
    logic [CNT_W-1:0]      cnt;
    logic [2:0]            cmd_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [3:0]            gnt_q;
    logic [3:0]            ack_q;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [3:0]            req;
    logic [3:0]            grant;
    logic [1:0]            grant_idx;
    logic                  advance;
    logic [2:0]            sel_cmd;
    logic [IDX_W-1:0]      sel_idx;
    logic [DATA_WIDTH-1:0] sel_data;

    for (genvar n = 0; n < 4; n++) begin : g_req
        assign req[n] = is_mem_cmd(bus.mbus_cmd_i[3*n +: 3]);
    end

    assign advance = (state == IDLE) && (|req);

    mesi_isc_mem_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_cmd  = bus.mbus_cmd_i[3*int'(grant_idx) +: 3];
        sel_idx  = bus.mbus_addr_i[ADDR_WIDTH*int'(grant_idx) +: IDX_W];
        sel_data = bus.mbus_data_wr_i[DATA_WIDTH*int'(grant_idx) +: DATA_WIDTH];
    end

    // Inputs are captured only on the grant edge; the bus may change afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cmd_q   <= MBUS_CMD_NOP;
            idx_q   <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            rd_data <= '0;
        end else begin
            ack_q <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        cmd_q  <= sel_cmd;
                        idx_q  <= sel_idx;
                        data_q <= sel_data;
                        gnt_q  <= grant;
                        cnt    <= CNT_W'(LATENCY - 1);
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state <= ACK;
                        ack_q <= gnt_q;
                        if (cmd_q == MBUS_CMD_RD) begin
                            rd_data <= mem[idx_q];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if ((state == ACK) && (cmd_q == MBUS_CMD_WR)) begin
            mem[idx_q] <= data_q;
        end
    end

`ifdef MESI_ISC_MEM_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count_o <= '0;
            wr_count_o <= '0;
        end else if (state == ACK) begin
            if ((cmd_q == MBUS_CMD_RD) && (rd_count_o != 16'hFFFF)) begin
                rd_count_o <= rd_count_o + 16'd1;
            end
            if ((cmd_q == MBUS_CMD_WR) && (wr_count_o != 16'hFFFF)) begin
                wr_count_o <= wr_count_o + 16'd1;
            end
        end
    end
`endif

    assign bus.mbus_ack_o     = ack_q | bus.isc_mbus_ack_i;
    assign bus.mbus_data_rd_o = rd_data;
    assign bus.busy_o         = (state != IDLE);
    assign bus.state          = state;

endmodule
